// File: rtl/forward_pipe_slice_pkg.sv
// Shared defaults and helpers for the forward-registered pipeline slice.
package forward_pipe_slice_pkg;

  localparam int unsigned FPS_L_DEFAULT     = 8;
  localparam int unsigned FPS_DEPTH_DEFAULT = 2;
  localparam int unsigned FPS_DEPTH_MIN     = 1;
  localparam int unsigned FPS_DEPTH_MAX     = 8;

  // Width needed to hold an occupancy value in 0..depth.
  function automatic int unsigned count_width(int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/forward_pipe_slice_if.sv
// Streaming boundary of the forward pipeline slice: producer (_f) side, consumer (_b) side, occupancy.
interface forward_pipe_slice_if
  import forward_pipe_slice_pkg::*;
#(
  parameter int unsigned L     = FPS_L_DEFAULT,
  parameter int unsigned DEPTH = FPS_DEPTH_DEFAULT
);

  localparam int unsigned CW = count_width(DEPTH);

  logic          ready_f;
  logic          valid_f;
  logic [L-1:0]  data_f;
  logic          ready_b;
  logic          valid_b;
  logic [L-1:0]  data_b;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  modport slave (
    input  valid_f, data_f, ready_b,
    output ready_f, valid_b, data_b, count, full, empty
  );

  modport master (
    output valid_f, data_f, ready_b,
    input  ready_f, valid_b, data_b, count, full, empty
  );

endinterface

// File: rtl/forward_stage.sv
// One valid/data register stage; its ready is combinational so bubbles collapse through the chain.
module forward_stage #(
  parameter int unsigned L = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [L-1:0] in_data,
  input  logic         in_ready_next,
  output logic         out_valid,
  output logic [L-1:0] out_data,
  output logic         out_ready
);

  // An empty stage can always take a beat, even if everything downstream is stalled.
  assign out_ready = in_ready_next | ~out_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (out_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/forward_pipe_slice.sv
// Forward-registered pipeline slice: DEPTH valid/data stages, pass-through ready, registered occupancy.
module forward_pipe_slice
  import forward_pipe_slice_pkg::*;
#(
  parameter int unsigned L     = FPS_L_DEFAULT,
  parameter int unsigned DEPTH = FPS_DEPTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  forward_pipe_slice_if.slave  bus
);

  localparam int unsigned CW = count_width(DEPTH);

  if (DEPTH < FPS_DEPTH_MIN || DEPTH > FPS_DEPTH_MAX) begin : g_bad_depth
    $error("forward_pipe_slice: DEPTH=%0d outside %0d..%0d", DEPTH, FPS_DEPTH_MIN, FPS_DEPTH_MAX);
  end

  // Stage 0 faces the producer; stage DEPTH-1 drives the consumer.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic         in_valid;
    logic [L-1:0] in_data;
    logic         ready_next;
    logic         stage_valid;
    logic [L-1:0] stage_data;
    logic         stage_ready;

    if (i == 0) begin : g_first
      assign in_valid = bus.valid_f;
      assign in_data  = bus.data_f;
    end else begin : g_chain
      assign in_valid = g_stage[i-1].stage_valid;
      assign in_data  = g_stage[i-1].stage_data;
    end

    if (i == DEPTH - 1) begin : g_last
      assign ready_next = bus.ready_b;
    end else begin : g_mid
      assign ready_next = g_stage[i+1].stage_ready;
    end

    forward_stage #(.L(L)) u_stage (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_data       (in_data),
      .in_ready_next (ready_next),
      .out_valid     (stage_valid),
      .out_data      (stage_data),
      .out_ready     (stage_ready)
    );
  end

  assign bus.ready_f = g_stage[0].stage_ready & rst;
  assign bus.valid_b = g_stage[DEPTH-1].stage_valid;
  assign bus.data_b  = g_stage[DEPTH-1].stage_data;

  logic          accept;
  logic          emit;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_nxt;
  logic          full_q;
  logic          empty_q;

  assign accept = bus.valid_f & bus.ready_f;
  assign emit   = bus.valid_b & bus.ready_b;

  always_comb begin
    count_nxt = count_q;
    if (accept && !emit) begin
      count_nxt = count_q + CW'(1);
    end else if (emit && !accept) begin
      count_nxt = count_q - CW'(1);
    end
  end

  // full/empty registered from the next count so they track count exactly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      count_q <= count_nxt;
      full_q  <= (count_nxt == CW'(DEPTH));
      empty_q <= (count_nxt == '0);
    end
  end

  assign bus.count = count_q;
  assign bus.full  = full_q;
  assign bus.empty = empty_q;

endmodule

// File: tb/tb_forward_pipe_slice.sv
// Bench for forward_pipe_slice: DEPTH=2 and DEPTH=4 instances share stimulus, checked against a beat-queue model.
`timescale 1ns/1ps
module tb_forward_pipe_slice;

  logic       clk;
  logic       rst;
  logic       valid_f;
  logic [7:0] data_f;
  logic       ready_b;

  int n_tests = 0;
  int n_fail  = 0;

  forward_pipe_slice_if #(.L(8), .DEPTH(2)) bus2 ();
  forward_pipe_slice_if #(.L(8), .DEPTH(4)) bus4 ();

  assign bus2.valid_f = valid_f;
  assign bus2.data_f  = data_f;
  assign bus2.ready_b = ready_b;
  assign bus4.valid_f = valid_f;
  assign bus4.data_f  = data_f;
  assign bus4.ready_b = ready_b;

  forward_pipe_slice #(.L(8), .DEPTH(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));
  forward_pipe_slice #(.L(8), .DEPTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

  int act_rf [2];
  int act_v [2];
  int act_d [2];
  int act_cnt [2];
  int act_full [2];
  int act_empty [2];

  assign act_rf[0]    = int'(bus2.ready_f);
  assign act_v[0]     = int'(bus2.valid_b);
  assign act_d[0]     = int'(bus2.data_b);
  assign act_cnt[0]   = int'(bus2.count);
  assign act_full[0]  = int'(bus2.full);
  assign act_empty[0] = int'(bus2.empty);
  assign act_rf[1]    = int'(bus4.ready_f);
  assign act_v[1]     = int'(bus4.valid_b);
  assign act_d[1]     = int'(bus4.data_b);
  assign act_cnt[1]   = int'(bus4.count);
  assign act_full[1]  = int'(bus4.full);
  assign act_empty[1] = int'(bus4.empty);

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Model: accepted beats in order with their accept edge; a beat reaches the output
  // DEPTH-1 edges after acceptance, but never before its predecessor has left.
  logic [7:0] bd [2][64];
  int         ba [2][64];
  int         hd [2];
  int         tl [2];
  int         ec [2];
  int         last_emit [2];
  logic [7:0] last_out [2];

  function automatic int dep(int m);
    return (m == 0) ? 2 : 4;
  endfunction

  function automatic int occ(int m);
    return tl[m] - hd[m];
  endfunction

  function automatic bit m_valid(int m);
    int r;
    if (occ(m) == 0) return 1'b0;
    r = ba[m][hd[m] % 64] + dep(m) - 1;
    if (last_emit[m] > r) r = last_emit[m];
    return (r <= ec[m]);
  endfunction

  function automatic int m_data(int m);
    return m_valid(m) ? int'(bd[m][hd[m] % 64]) : int'(last_out[m]);
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      hd[m] = 0; tl[m] = 0; ec[m] = 0; last_emit[m] = 0; last_out[m] = 8'h00;
    end
  endtask

  task automatic model_edge();
    for (int m = 0; m < 2; m++) begin
      bit em;
      bit ac;
      em = m_valid(m) && ready_b;
      ac = valid_f && ((occ(m) < dep(m)) || ready_b);
      ec[m]++;
      if (em) begin
        last_out[m] = bd[m][hd[m] % 64];
        hd[m]++;
        last_emit[m] = ec[m];
      end
      if (ac) begin
        bd[m][tl[m] % 64] = data_f;
        ba[m][tl[m] % 64] = ec[m];
        tl[m]++;
      end
    end
  endtask

  task automatic check(string name, int m, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s D%0d at %0t: got %0d (0x%0h) expected %0d (0x%0h)",
               name, dep(m), $time, act, act, exp, exp);
    end
  endtask

  task automatic compare_all();
    for (int m = 0; m < 2; m++) begin
      check("valid_b", m, act_v[m], int'(m_valid(m)));
      check("data_b", m, act_d[m], m_data(m));
      check("count", m, act_cnt[m], occ(m));
      check("full", m, act_full[m], int'(occ(m) == dep(m)));
      check("empty", m, act_empty[m], int'(occ(m) == 0));
      check("ready_f", m, act_rf[m], int'(rst && ((occ(m) < dep(m)) || ready_b)));
    end
  endtask

  // One clock: model follows the edge, then every output is compared on the falling edge.
  task automatic step();
    @(posedge clk);
    if (rst) model_edge();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    rst = 1'b0; valid_f = 1'b1; data_f = 8'hAA; ready_b = 1'b1;
    model_reset();

    // Reset held with a beat offered
    repeat (3) begin
      step();
      check("rst_ready_f", 0, act_rf[0], 0);
      check("rst_valid_b", 0, act_v[0], 0);
      check("rst_data_b", 0, act_d[0], 8'h00);
      check("rst_count", 0, act_cnt[0], 0);
      check("rst_empty", 0, act_empty[0], 1);
    end
    rst = 1'b1; valid_f = 1'b0;
    #1;
    check("release_ready_f", 0, act_rf[0], 1);
    check("release_ready_f", 1, act_rf[1], 1);

    // Streaming 01..10 with ready_b high
    ready_b = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      valid_f = 1'b1; data_f = 8'(i);
      step();
      if (i == 1) begin
        check("stream_latency", 0, act_v[0], 0);
      end else begin
        check("stream_valid", 0, act_v[0], 1);
        check("stream_data", 0, act_d[0], i - 1);
        check("stream_count", 0, act_cnt[0], 2);
      end
    end
    valid_f = 1'b0;
    step();
    check("stream_last", 0, act_d[0], 8'h10);
    repeat (6) step();

    // Stall and fill
    ready_b = 1'b0; valid_f = 1'b1; data_f = 8'h11;
    #1;
    check("fill_ready_empty", 0, act_rf[0], 1);
    step();
    data_f = 8'h22;
    step();
    data_f = 8'h33;
    #1;
    check("fill_ready_full", 0, act_rf[0], 0);
    check("fill_full", 0, act_full[0], 1);
    check("fill_count", 0, act_cnt[0], 2);
    check("fill_valid", 0, act_v[0], 1);
    check("fill_data", 0, act_d[0], 8'h11);
    repeat (3) begin
      step();
      check("stall_valid", 0, act_v[0], 1);
      check("stall_data", 0, act_d[0], 8'h11);
    end

    // Full pass-through
    ready_b = 1'b1;
    #1;
    check("pass_ready_f", 0, act_rf[0], 1);
    step();
    check("pass_data", 0, act_d[0], 8'h22);
    check("pass_count", 0, act_cnt[0], 2);
    valid_f = 1'b0;
    step();
    check("pass_data", 0, act_d[0], 8'h33);
    check("pass_count", 0, act_cnt[0], 1);
    step();
    check("pass_drained", 0, act_v[0], 0);
    check("pass_count", 0, act_cnt[0], 0);
    repeat (8) step();

    // Bubble collapse on DEPTH=4
    ready_b = 1'b0;
    for (int k = 0; k < 7; k++) begin
      if (k % 2 == 0) begin
        valid_f = 1'b1; data_f = 8'(8'h41 + k / 2);
      end else begin
        valid_f = 1'b0;
      end
      step();
      check("bubble_count", 1, act_cnt[1], k / 2 + 1);
    end
    check("bubble_full", 1, act_full[1], 1);
    valid_f = 1'b0; ready_b = 1'b1;
    #1;
    check("bubble_head", 1, act_d[1], 8'h41);
    for (int j = 1; j <= 3; j++) begin
      step();
      check("bubble_order", 1, act_d[1], 8'h41 + j);
    end
    step();
    check("bubble_drained", 1, act_v[1], 0);
    repeat (4) step();

    // Asynchronous reset pulse between edges
    ready_b = 1'b0; valid_f = 1'b1; data_f = 8'h51;
    step();
    data_f = 8'h52;
    step();
    valid_f = 1'b0;
    #1;
    check("pre_rst_count", 0, act_cnt[0], 2);
    check("pre_rst_valid", 0, act_v[0], 1);
    #1 rst = 1'b0;
    #2;
    for (int m = 0; m < 2; m++) begin
      check("async_valid_b", m, act_v[m], 0);
      check("async_data_b", m, act_d[m], 0);
      check("async_count", m, act_cnt[m], 0);
      check("async_empty", m, act_empty[m], 1);
      check("async_full", m, act_full[m], 0);
      check("async_ready_f", m, act_rf[m], 0);
    end
    model_reset();
    #2 rst = 1'b1;
    #1;
    check("rerelease_ready_f", 0, act_rf[0], 1);
    check("rerelease_ready_f", 1, act_rf[1], 1);
    ready_b = 1'b1;
    repeat (5) begin
      step();
      check("no_stale", 0, act_v[0], 0);
      check("no_stale", 1, act_v[1], 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
